decode_stage: RTL and testbench

- Registered RV32I/RV64I instruction decode stage with a valid/ready handshake on both sides.
- Accepts a fetched instruction word and PC, classifies the major opcode, extracts register and function fields, and generates the sign-extended immediate.
- Flags illegal encodings and presents all results one cycle later.
- Sits between the fetch and execute stages; it is the parametrised successor of the flat opcode enumeration, adding an RV64 mode, an optional M-extension mode, and extra opcode classes.

---
 rtl/decode_stage_pkg.sv | 36 +++
 rtl/decode_stage_imm_gen.sv | 35 +++
 rtl/decode_stage.sv | 158 +++++++++++++++
 tb/tb_decode_stage.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: shared decode types and constants.
//   opcode_t    - RV32I/RV64I major opcode classes (instr[6:0])
//   imm_fmt_t   - immediate format selector used by imm_gen
//   FUNCT7_*    - funct7 values accepted on OP / OP_32
package decode_stage_pkg;

   typedef enum logic [6:0] {
      LOAD      = 7'b0000011,
      MISC_MEM  = 7'b0001111,
      OP_IMM    = 7'b0010011,
      AUIPC     = 7'b0010111,
      OP_IMM_32 = 7'b0011011,
      STORE     = 7'b0100011,
      OP        = 7'b0110011,
      LUI       = 7'b0110111,
      OP_32     = 7'b0111011,
      BRANCH    = 7'b1100011,
      JALR      = 7'b1100111,
      JAL       = 7'b1101111,
      SYSTEM    = 7'b1110011
   } opcode_t;

   typedef enum logic [2:0] {
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J,
      IMM_R
   } imm_fmt_t;

   localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
   localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
   localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// decode_stage_imm_gen: combinational immediate generator.
//   instr_i  [31:0]     instruction word
//   fmt_i    imm_fmt_t  immediate format
//   imm_o    [XLEN-1:0] immediate, sign-extended from instr[31]; 0 for IMM_R
module decode_stage_imm_gen
   import decode_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr_i,
   input  imm_fmt_t        fmt_i,
   output logic [XLEN-1:0] imm_o
);

   // Every format fits in 32 bits with instr[31] as the sign, so build a
   // signed 32-bit value and let the size cast replicate the sign to XLEN.
   logic signed [31:0] raw_s;

   always_comb begin
      raw_s = '0;
      case (fmt_i)
         IMM_I: raw_s = {{20{instr_i[31]}}, instr_i[31:20]};
         IMM_S: raw_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
         IMM_B: raw_s = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25],
                         instr_i[11:8], 1'b0};
         IMM_U: raw_s = {instr_i[31:12], 12'b0};
         IMM_J: raw_s = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20],
                         instr_i[30:21], 1'b0};
         default: raw_s = '0;
      endcase
   end

   assign imm_o = XLEN'(raw_s);

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I/RV64I decode stage with valid/ready on both sides.
//   clk, rst_n          clock, async active-low reset
//   flush               drop the registered result and any acceptance this cycle
//   in_valid/in_ready   upstream handshake; in_instr, in_pc from fetch
//   out_valid/out_ready downstream handshake
//   out_pc, out_opcode, out_rd, out_rs1, out_rs2, out_funct3, out_funct7,
//   out_imm, out_is_mext, out_illegal  decoded fields, one cycle after accept
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter bit EN_M      = 1'b0,
   parameter bit EN_SYSTEM = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [6:0]      out_opcode,
   output logic [4:0]      out_rd,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [2:0]      out_funct3,
   output logic [6:0]      out_funct7,
   output logic [XLEN-1:0] out_imm,
   output logic            out_is_mext,
   output logic            out_illegal
);

   logic [6:0]      opc;
   logic [2:0]      f3;
   logic [6:0]      f7;
   imm_fmt_t        fmt_d;
   logic [XLEN-1:0] imm_d;
   logic            illegal_d;
   logic            mext_d;
   logic            m_cand;
   logic            accept;
   logic            valid_d, valid_q;

   logic [XLEN-1:0] pc_q;
   logic [6:0]      opcode_q;
   logic [4:0]      rd_q, rs1_q, rs2_q;
   logic [2:0]      funct3_q;
   logic [6:0]      funct7_q;
   logic [XLEN-1:0] imm_q;
   logic            mext_q;
   logic            illegal_q;

   assign opc = in_instr[6:0];
   assign f3  = in_instr[14:12];
   assign f7  = in_instr[31:25];

   // Illegal encodings still decode their fields; only is_mext is masked.
   always_comb begin
      fmt_d     = IMM_R;
      illegal_d = 1'b0;
      m_cand    = 1'b0;
      case (opc)
         LOAD, OP_IMM: fmt_d = IMM_I;
         JALR: begin
            fmt_d = IMM_I;
            if (f3 != 3'b000) illegal_d = 1'b1;
         end
         OP_IMM_32: begin
            fmt_d = IMM_I;
            if (XLEN == 32) illegal_d = 1'b1;
         end
         MISC_MEM, SYSTEM: begin
            fmt_d = IMM_I;
            if (!EN_SYSTEM) illegal_d = 1'b1;
         end
         STORE: fmt_d = IMM_S;
         BRANCH: begin
            fmt_d = IMM_B;
            if (f3 == 3'b010 || f3 == 3'b011) illegal_d = 1'b1;
         end
         LUI, AUIPC: fmt_d = IMM_U;
         JAL:        fmt_d = IMM_J;
         OP, OP_32: begin
            fmt_d  = IMM_R;
            m_cand = EN_M && (f7 == FUNCT7_MEXT);
            if (!(f7 == FUNCT7_BASE || f7 == FUNCT7_ALT || m_cand))
               illegal_d = 1'b1;
            if (opc == OP_32 && XLEN == 32) illegal_d = 1'b1;
         end
         // Unknown opcode: IMM_R forces a zero immediate.
         default: illegal_d = 1'b1;
      endcase
      if (in_instr[1:0] != 2'b11) illegal_d = 1'b1;
      mext_d = m_cand && !illegal_d;
   end

   decode_stage_imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .instr_i (in_instr),
      .fmt_i   (fmt_d),
      .imm_o   (imm_d)
   );

   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready && !flush;

   always_comb begin
      valid_d = valid_q;
      if (flush)          valid_d = 1'b0;
      else if (accept)    valid_d = 1'b1;
      else if (out_ready) valid_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         pc_q      <= '0;
         opcode_q  <= '0;
         rd_q      <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         funct3_q  <= '0;
         funct7_q  <= '0;
         imm_q     <= '0;
         mext_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
         if (accept) begin
            pc_q      <= in_pc;
            opcode_q  <= opc;
            rd_q      <= in_instr[11:7];
            rs1_q     <= in_instr[19:15];
            rs2_q     <= in_instr[24:20];
            funct3_q  <= f3;
            funct7_q  <= f7;
            imm_q     <= imm_d;
            mext_q    <= mext_d;
            illegal_q <= illegal_d;
         end
      end
   end

   assign out_valid   = valid_q;
   assign out_pc      = pc_q;
   assign out_opcode  = opcode_q;
   assign out_rd      = rd_q;
   assign out_rs1     = rs1_q;
   assign out_rs2     = rs2_q;
   assign out_funct3  = funct3_q;
   assign out_funct7  = funct7_q;
   assign out_imm     = imm_q;
   assign out_is_mext = mext_q;
   assign out_illegal = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: two decode_stage instances share one stimulus stream:
//   d32: XLEN=32, EN_M=0, EN_SYSTEM=1
//   d64: XLEN=64, EN_M=1, EN_SYSTEM=0
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [31:0] in_instr = '0;
   logic [63:0] pc = '0;

   logic        a_in_ready, a_valid, a_mext, a_ill;
   logic [31:0] a_pc, a_imm;
   logic [6:0]  a_op, a_f7;
   logic [4:0]  a_rd, a_rs1, a_rs2;
   logic [2:0]  a_f3;

   logic        b_in_ready, b_valid, b_mext, b_ill;
   logic [63:0] b_pc, b_imm;
   logic [6:0]  b_op, b_f7;
   logic [4:0]  b_rd, b_rs1, b_rs2;
   logic [2:0]  b_f3;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   decode_stage #(.XLEN(32), .EN_M(1'b0), .EN_SYSTEM(1'b1)) d32 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
      .in_ready(a_in_ready), .in_instr(in_instr), .in_pc(pc[31:0]),
      .out_valid(a_valid), .out_ready(out_ready), .out_pc(a_pc),
      .out_opcode(a_op), .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2),
      .out_funct3(a_f3), .out_funct7(a_f7), .out_imm(a_imm),
      .out_is_mext(a_mext), .out_illegal(a_ill)
   );

   decode_stage #(.XLEN(64), .EN_M(1'b1), .EN_SYSTEM(1'b0)) d64 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
      .in_ready(b_in_ready), .in_instr(in_instr), .in_pc(pc),
      .out_valid(b_valid), .out_ready(out_ready), .out_pc(b_pc),
      .out_opcode(b_op), .out_rd(b_rd), .out_rs1(b_rs1), .out_rs2(b_rs2),
      .out_funct3(b_f3), .out_funct7(b_f7), .out_imm(b_imm),
      .out_is_mext(b_mext), .out_illegal(b_ill)
   );

   typedef struct {
      logic [31:0] instr;
      logic [6:0]  op;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm32;
      logic        ill32, mx32;
      logic [63:0] imm64;
      logic        ill64, mx64;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chk_vec(input int i, input vec_t v, input logic [63:0] epc);
      string t;
      t = $sformatf("v%0d", i);
      chk({t, " valid32"}, 64'(a_valid), 64'd1);
      chk({t, " valid64"}, 64'(b_valid), 64'd1);
      chk({t, " pc32"}, 64'(a_pc), 64'(epc[31:0]));
      chk({t, " pc64"}, b_pc, epc);
      chk({t, " op"}, 64'(a_op), 64'(v.op));
      chk({t, " op64"}, 64'(b_op), 64'(v.op));
      chk({t, " rd"}, 64'(a_rd), 64'(v.rd));
      chk({t, " rs1"}, 64'(a_rs1), 64'(v.rs1));
      chk({t, " rs2"}, 64'(b_rs2), 64'(v.rs2));
      chk({t, " f3"}, 64'(a_f3), 64'(v.f3));
      chk({t, " f7"}, 64'(b_f7), 64'(v.f7));
      chk({t, " imm32"}, 64'(a_imm), 64'(v.imm32));
      chk({t, " ill32"}, 64'(a_ill), 64'(v.ill32));
      chk({t, " mext32"}, 64'(a_mext), 64'(v.mx32));
      chk({t, " imm64"}, b_imm, v.imm64);
      chk({t, " ill64"}, 64'(b_ill), 64'(v.ill64));
      chk({t, " mext64"}, 64'(b_mext), 64'(v.mx64));
   endtask

   initial begin
      //          instr         op     rd  rs1 rs2 f3  f7     imm32         i32 m32 imm64                  i64 m64
      vecs[0]  = '{32'hFFF00093, 7'h13, 1,  0,  31, 0, 7'h7F, 32'hFFFFFFFF, 0,  0,  64'hFFFFFFFFFFFFFFFF, 0,  0};
      vecs[1]  = '{32'hFE000EE3, 7'h63, 29, 0,  0,  0, 7'h7F, 32'hFFFFFFFC, 0,  0,  64'hFFFFFFFFFFFFFFFC, 0,  0};
      vecs[2]  = '{32'h022081B3, 7'h33, 3,  1,  2,  0, 7'h01, 32'h0,        1,  0,  64'h0,                0,  1};
      vecs[3]  = '{32'h00000013, 7'h13, 0,  0,  0,  0, 7'h00, 32'h0,        0,  0,  64'h0,                0,  0};
      vecs[4]  = '{32'h00000000, 7'h00, 0,  0,  0,  0, 7'h00, 32'h0,        1,  0,  64'h0,                1,  0};
      vecs[5]  = '{32'h0000001B, 7'h1B, 0,  0,  0,  0, 7'h00, 32'h0,        1,  0,  64'h0,                0,  0};
      vecs[6]  = '{32'hFE512C23, 7'h23, 24, 2,  5,  2, 7'h7F, 32'hFFFFFFF8, 0,  0,  64'hFFFFFFFFFFFFFFF8, 0,  0};
      vecs[7]  = '{32'h800002B7, 7'h37, 5,  0,  0,  0, 7'h40, 32'h80000000, 0,  0,  64'hFFFFFFFF80000000, 0,  0};
      vecs[8]  = '{32'hFFFFF06F, 7'h6F, 0,  31, 31, 7, 7'h7F, 32'hFFFFFFFE, 0,  0,  64'hFFFFFFFFFFFFFFFE, 0,  0};
      vecs[9]  = '{32'h004110E7, 7'h67, 1,  2,  4,  1, 7'h00, 32'h4,        1,  0,  64'h4,                1,  0};
      vecs[10] = '{32'h00002063, 7'h63, 0,  0,  0,  2, 7'h00, 32'h0,        1,  0,  64'h0,                1,  0};
      vecs[11] = '{32'h00000073, 7'h73, 0,  0,  0,  0, 7'h00, 32'h0,        0,  0,  64'h0,                1,  0};
      vecs[12] = '{32'h04000033, 7'h33, 0,  0,  0,  0, 7'h02, 32'h0,        1,  0,  64'h0,                1,  0};
      vecs[13] = '{32'h402081B3, 7'h33, 3,  1,  2,  0, 7'h20, 32'h0,        0,  0,  64'h0,                0,  0};
      vecs[14] = '{32'h00000012, 7'h12, 0,  0,  0,  0, 7'h00, 32'h0,        1,  0,  64'h0,                1,  0};
      vecs[15] = '{32'h022081BB, 7'h3B, 3,  1,  2,  0, 7'h01, 32'h0,        1,  0,  64'h0,                0,  1};

      // Reset state
      #3;
      chk("rst valid32", 64'(a_valid), 64'd0);
      chk("rst valid64", 64'(b_valid), 64'd0);
      chk("rst imm64", b_imm, 64'd0);
      chk("rst pc32", 64'(a_pc), 64'd0);
      chk("rst ill32", 64'(a_ill), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rel in_ready32", 64'(a_in_ready), 64'd1);
      chk("rel in_ready64", 64'(b_in_ready), 64'd1);

      // Back-to-back vector stream at full throughput
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         in_valid  = 1'b1;
         out_ready = 1'b1;
         in_instr  = vecs[i].instr;
         pc        = 64'h0000_0001_0000_0100 + 64'(4 * i);
         @(negedge clk);
         chk_vec(i, vecs[i], 64'h0000_0001_0000_0100 + 64'(4 * i));
      end
      in_valid = 1'b0;

      // Stall: three cycles of out_ready=0 hold everything
      @(negedge clk);
      in_valid = 1'b1; in_instr = 32'hFFF00093; pc = 64'h200; out_ready = 1'b1;
      @(negedge clk);
      in_instr = 32'hFE000EE3; pc = 64'h204; out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("stall%0d in_ready", c), 64'(a_in_ready), 64'd0);
         chk($sformatf("stall%0d valid", c), 64'(a_valid), 64'd1);
         chk($sformatf("stall%0d imm", c), 64'(a_imm), 64'hFFFFFFFF);
         chk($sformatf("stall%0d pc", c), 64'(b_pc), 64'h200);
         chk($sformatf("stall%0d rd", c), 64'(b_rd), 64'd1);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      chk("unstall in_ready", 64'(a_in_ready), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("unstall imm", 64'(a_imm), 64'hFFFFFFFC);
      chk("unstall op", 64'(b_op), 64'h63);
      chk("unstall pc", 64'(a_pc), 64'h204);

      // Flush beats a simultaneous accept
      @(negedge clk);
      in_valid = 1'b1; in_instr = 32'h00000013; pc = 64'h300; flush = 1'b1;
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      chk("flush acc valid32", 64'(a_valid), 64'd0);
      chk("flush acc valid64", 64'(b_valid), 64'd0);

      // Flush overrides a stall
      in_valid = 1'b1; in_instr = 32'h00000013; pc = 64'h304;
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      chk("pre-flush stall valid", 64'(a_valid), 64'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush stall valid", 64'(a_valid), 64'd0);
      #1;
      chk("flush stall in_ready", 64'(a_in_ready), 64'd1);
      out_ready = 1'b1;

      // Async reset in the middle of a stall
      @(negedge clk);
      in_valid = 1'b1; in_instr = 32'h022081B3; pc = 64'h308;
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst valid64", 64'(b_valid), 64'd0);
      chk("arst mext64", 64'(b_mext), 64'd0);
      chk("arst pc64", b_pc, 64'd0);
      chk("arst rd32", 64'(a_rd), 64'd0);
      chk("arst ill32", 64'(a_ill), 64'd0);
      chk("arst op32", 64'(a_op), 64'd0);
      @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1;
      #1;
      chk("arst rel in_ready", 64'(b_in_ready), 64'd1);
      in_valid = 1'b1; in_instr = 32'h800002B7; pc = 64'h400;
      @(negedge clk);
      in_valid = 1'b0;
      chk("post rst valid", 64'(b_valid), 64'd1);
      chk("post rst imm64", b_imm, 64'hFFFFFFFF80000000);
      chk("post rst imm32", 64'(a_imm), 64'h80000000);
      chk("post rst pc", b_pc, 64'h400);
      @(negedge clk);
      chk("drain valid", 64'(a_valid), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
